// File: rtl/mult_div_unit_if.sv
// HI/LO unit request/response bundle: operands, opcode and start pulse in,
// HI/LO registers and busy flag out.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic [2:0]       MDOp;
  logic             Start;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;

  modport master (
    output D1, D2, MDOp, Start,
    input  HI, LO, Busy
  );

  modport slave (
    input  D1, D2, MDOp, Start,
    output HI, LO, Busy
  );
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO multiply/divide unit: fixed-latency mult/div with
// busy back-pressure, plus direct HI/LO writes (mthi/mtlo) while idle.
module mult_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   md
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic [WIDTH-1:0]   op_a_q,  op_a_d;
  logic [WIDTH-1:0]   op_b_q,  op_b_d;
  logic               sgn_q,   sgn_d;

  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, den, q_mag, r_mag, quo, rem;
  logic               start_mul, start_div;

  // Datapath from latched operands; signed divide done on magnitudes so the
  // quotient truncates toward zero and the remainder follows the dividend.
  always_comb begin
    a_ext = sgn_q ? {{WIDTH{op_a_q[WIDTH-1]}}, op_a_q} : {{WIDTH{1'b0}}, op_a_q};
    b_ext = sgn_q ? {{WIDTH{op_b_q[WIDTH-1]}}, op_b_q} : {{WIDTH{1'b0}}, op_b_q};
    prod  = a_ext * b_ext;

    a_neg = sgn_q & op_a_q[WIDTH-1];
    b_neg = sgn_q & op_b_q[WIDTH-1];
    a_mag = a_neg ? (WIDTH'(0) - op_a_q) : op_a_q;
    b_mag = b_neg ? (WIDTH'(0) - op_b_q) : op_b_q;
    den   = (b_mag == WIDTH'(0)) ? WIDTH'(1) : b_mag;
    q_mag = a_mag / den;
    r_mag = a_mag % den;
    quo   = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
    rem   = a_neg ? (WIDTH'(0) - r_mag) : r_mag;
  end

  assign start_mul = md.Start && ((md.MDOp == OP_MULT) || (md.MDOp == OP_MULTU));
  assign start_div = md.Start && ((md.MDOp == OP_DIV)  || (md.MDOp == OP_DIVU));

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sgn_d   = sgn_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start_mul) begin
          state_d = ST_MULT;
          cnt_d   = CNT_W'(MULT_CYCLES);
          busy_d  = 1'b1;
          op_a_d  = md.D1;
          op_b_d  = md.D2;
          sgn_d   = (md.MDOp == OP_MULT);
        end else if (start_div) begin
          state_d = ST_DIV;
          cnt_d   = CNT_W'(DIV_CYCLES);
          busy_d  = 1'b1;
          op_a_d  = md.D1;
          op_b_d  = md.D2;
          sgn_d   = (md.MDOp == OP_DIV);
        end else if (md.MDOp == OP_MTHI) begin
          hi_d = md.D1;
        end else if (md.MDOp == OP_MTLO) begin
          lo_d = md.D1;
        end
      end
      ST_MULT: begin
        if (cnt_q <= CNT_W'(1)) begin
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q <= CNT_W'(1)) begin
          // Divide by zero leaves HI/LO untouched.
          if (op_b_q != WIDTH'(0)) begin
            hi_d = rem;
            lo_d = quo;
          end
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sgn_q   <= sgn_d;
    end
  end

  assign md.HI   = hi_q;
  assign md.LO   = lo_q;
  assign md.Busy = busy_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed boundary cases plus
// randomized mult/div traffic against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) mdif ();

  mult_div_unit #(
    .WIDTH       (W),
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdif)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi     = 32'd0;
  logic [31:0] m_lo     = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: architectural result of one accepted operation.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      3'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd3: if (b != 32'd0) begin
              sq = sa / sb; sr = sa % sb;
              m_lo = sq[31:0]; m_hi = sr[31:0];
            end
      3'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  task automatic check_hl(input string tag);
    chk({tag, "_hi"}, mdif.HI, m_hi);
    chk({tag, "_lo"}, mdif.LO, m_lo);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk({tag, "_busy"}, 32'(mdif.Busy), 32'd0);
      check_hl(tag);
    end
  endtask

  // Issue one op, then measure busy length; intf=1 re-starts divu while busy,
  // intf=2 issues mtlo while busy. Operand ports are scrambled after acceptance.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc, input int intf);
    int n;
    mdif.Start = 1'b1; mdif.MDOp = op; mdif.D1 = a; mdif.D2 = b;
    @(posedge clk); #1;
    mdif.Start = 1'b0; mdif.MDOp = 3'd0; mdif.D1 = $urandom; mdif.D2 = $urandom;
    chk({tag, "_busy_rise"}, 32'(mdif.Busy), 32'd1);
    model(op, a, b);
    n = 0;
    while (mdif.Busy === 1'b1 && n < 200) begin
      if (n == 1 && intf == 1) begin
        mdif.Start = 1'b1; mdif.MDOp = 3'd4; mdif.D1 = $urandom; mdif.D2 = $urandom | 32'd1;
      end else if (n == 1 && intf == 2) begin
        mdif.MDOp = 3'd6; mdif.D1 = $urandom;
      end else begin
        mdif.Start = 1'b0; mdif.MDOp = 3'd0; mdif.D1 = $urandom; mdif.D2 = $urandom;
      end
      n++;
      @(posedge clk); #1;
    end
    mdif.Start = 1'b0; mdif.MDOp = 3'd0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
    check_hl(tag);
  endtask

  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] val);
    mdif.MDOp = op; mdif.D1 = val;
    @(posedge clk); #1;
    mdif.MDOp = 3'd0;
    if (op == 3'd5) m_hi = val; else m_lo = val;
    chk({tag, "_busy"}, 32'(mdif.Busy), 32'd0);
    check_hl(tag);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1;
    mdif.Start = 1'b0; mdif.MDOp = 3'd0; mdif.D1 = 32'd0; mdif.D2 = 32'd0;
    #3 reset = 1'b0;
    #1;
    chk("in_reset_busy", 32'(mdif.Busy), 32'd0);
    check_hl("in_reset");
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    idle_check("post_reset", 3);

    // Directed arithmetic with literal expectations.
    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, MC, 0);
    chk("mult_hi_lit", mdif.HI, 32'hFFFFFFFF);
    chk("mult_lo_lit", mdif.LO, 32'hFFFFFFFA);
    run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, MC, 0);
    chk("multu_hi_lit", mdif.HI, 32'h00000002);
    chk("multu_lo_lit", mdif.LO, 32'hFFFFFFFA);
    run_op("div_ign_start", 3'd3, 32'hFFFFFFF9, 32'd2, DC, 1);
    chk("div_lo_lit", mdif.LO, 32'hFFFFFFFD);
    chk("div_hi_lit", mdif.HI, 32'hFFFFFFFF);

    mt("mthi", 3'd5, 32'h12345678);
    chk("mthi_lit", mdif.HI, 32'h12345678);
    run_op("mult_mtlo_busy", 3'd1, $urandom, $urandom, MC, 2);

    mt("mthi_a", 3'd5, 32'h0000000A);
    mt("mtlo_b", 3'd6, 32'h0000000B);
    run_op("divu_zero", 3'd4, $urandom, 32'd0, DC, 0);
    chk("divu_zero_hi_lit", mdif.HI, 32'h0000000A);
    chk("divu_zero_lo_lit", mdif.LO, 32'h0000000B);

    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, DC, 0);
    chk("div_ovf_lo_lit", mdif.LO, 32'h80000000);
    chk("div_ovf_hi_lit", mdif.HI, 32'h00000000);

    // Start with non-arithmetic opcodes must not start anything.
    mdif.Start = 1'b1; mdif.MDOp = 3'd7; mdif.D1 = $urandom; mdif.D2 = $urandom;
    @(posedge clk); #1;
    chk("start_op7_busy", 32'(mdif.Busy), 32'd0);
    mdif.MDOp = 3'd0;
    @(posedge clk); #1;
    chk("start_op0_busy", 32'(mdif.Busy), 32'd0);
    mdif.Start = 1'b0;
    check_hl("start_ignored");

    // Randomized traffic.
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run_op("rand", rop, ra, rb, (rop <= 3'd2) ? MC : DC, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) == 0) mt("rand_mt", ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6, $urandom);
    end

    // Reset in the middle of a multiply.
    mdif.Start = 1'b1; mdif.MDOp = 3'd1; mdif.D1 = 32'd7; mdif.D2 = 32'd9;
    @(posedge clk); #1;
    mdif.Start = 1'b0; mdif.MDOp = 3'd0;
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("midop_reset_busy", 32'(mdif.Busy), 32'd0);
    check_hl("midop_reset");
    @(posedge clk); #3 reset = 1'b1;
    idle_check("after_midop_reset", 7);

    run_op("final_multu", 3'd2, $urandom, $urandom, MC, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
